// File: rtl/systolic_result_drain_pkg.sv
// Shared types and constants for the systolic result drain.
// SYS_DRAIN_RELU_EN (optional) clamps negative output elements to zero.
package systolic_result_drain_pkg;

  localparam int unsigned DEF_N          = 8;
  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_CNT_WIDTH  = $clog2(DEF_N + 1);

  typedef logic [DEF_DATA_WIDTH-1:0] result_row_t [DEF_N];

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } drain_state_t;

  // A column count must be able to hold N itself, so N+1 distinct values.
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/systolic_result_drain_column_buffer.sv
// One column of the result drain: N-deep write-once buffer with its own fill count.
module result_column_buffer
  import systolic_result_drain_pkg::*;
#(
  parameter int unsigned N          = 8,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CW         = cnt_width(N),
  parameter int unsigned RW         = $clog2(N)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clear_i,
  input  logic                  wr_en_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic [RW-1:0]         rd_idx_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic [CW-1:0]         count_o,
  output logic                  drop_o
);

  localparam logic [CW-1:0] FULL = CW'(N);

  logic [DATA_WIDTH-1:0] mem [N];
  logic [CW-1:0]         cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt <= '0;
      for (int unsigned i = 0; i < N; i++) mem[i] <= '0;
    end else if (clear_i) begin
      cnt <= '0;
    end else if (wr_en_i && (cnt < FULL)) begin
      mem[cnt[RW-1:0]] <= wr_data_i;
      cnt              <= cnt + CW'(1);
    end
  end

  assign rd_data_o = mem[rd_idx_i];
  assign count_o   = cnt;
  assign drop_o    = wr_en_i && (cnt == FULL);

endmodule

// File: rtl/systolic_result_drain.sv
// Collects skewed per-column array results and re-emits aligned rows on valid/ready.
// SYS_DRAIN_RELU_EN: when defined, negative output elements are driven as zero.
module systolic_result_drain
  import systolic_result_drain_pkg::*;
#(
  parameter int unsigned N          = 8,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  input  logic [N*DATA_WIDTH-1:0] south_i,
  input  logic [N-1:0]            south_valid_i,
  output logic [N*DATA_WIDTH-1:0] out_data_o,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [$clog2(N)-1:0]    out_row_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    overflow_o
);

  localparam int unsigned CW = cnt_width(N);
  localparam int unsigned RW = $clog2(N);

  drain_state_t          state;
  logic [RW-1:0]         row;
  logic                  overflow;
  logic [CW-1:0]         cnt     [N];
  logic [DATA_WIDTH-1:0] rd_data [N];
  logic [N-1:0]          drop;
  logic                  run;
  logic                  start_fire;
  logic                  accept;
  logic                  last_row;

  assign run        = (state == ST_RUN);
  assign start_fire = (state == ST_IDLE) && start_i;
  assign accept     = out_valid_o && out_ready_i;
  assign last_row   = (row == RW'(N - 1));

  for (genvar g = 0; g < N; g++) begin : g_col
    result_column_buffer #(
      .N          (N),
      .DATA_WIDTH (DATA_WIDTH),
      .CW         (CW),
      .RW         (RW)
    ) u_col (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .clear_i   (start_fire),
      .wr_en_i   (run && south_valid_i[g]),
      .wr_data_i (south_i[g*DATA_WIDTH +: DATA_WIDTH]),
      .rd_idx_i  (row),
      .rd_data_o (rd_data[g]),
      .count_o   (cnt[g]),
      .drop_o    (drop[g])
    );
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= ST_IDLE;
      row      <= '0;
      overflow <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_i) begin
            state    <= ST_RUN;
            row      <= '0;
            overflow <= 1'b0;
          end
        end
        ST_RUN: begin
          if (|drop) overflow <= 1'b1;
          // Row pointer never wraps; the final accept leaves it parked on N-1.
          if (accept) begin
            if (last_row) state <= ST_DONE;
            else          row   <= row + RW'(1);
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    out_valid_o = run;
    for (int unsigned j = 0; j < N; j++) begin
      if (!(cnt[j] > CW'(row))) out_valid_o = 1'b0;
    end
  end

  always_comb begin
    out_data_o = '0;
    for (int unsigned j = 0; j < N; j++) begin
`ifdef SYS_DRAIN_RELU_EN
      out_data_o[j*DATA_WIDTH +: DATA_WIDTH] =
        rd_data[j][DATA_WIDTH-1] ? '0 : rd_data[j];
`else
      out_data_o[j*DATA_WIDTH +: DATA_WIDTH] = rd_data[j];
`endif
    end
  end

  assign out_row_o  = row;
  assign busy_o     = run;
  assign done_o     = (state == ST_DONE);
  assign overflow_o = overflow;

endmodule

// File: tb/tb_systolic_result_drain.sv
// Self-checking bench for systolic_result_drain (N=4) against a queue-based model.
module tb_systolic_result_drain;

  localparam int N  = 4;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [N*DW-1:0] south;
  logic [N-1:0]    sv;
  logic [N*DW-1:0] out_data;
  logic            out_valid;
  logic            out_ready;
  logic [1:0]      out_row;
  logic            busy;
  logic            done;
  logic            ovf;

  always #5 clk = ~clk;

  systolic_result_drain #(.N(N), .DATA_WIDTH(DW)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .start_i       (start),
    .south_i       (south),
    .south_valid_i (sv),
    .out_data_o    (out_data),
    .out_valid_o   (out_valid),
    .out_ready_i   (out_ready),
    .out_row_o     (out_row),
    .busy_o        (busy),
    .done_o        (done),
    .overflow_o    (ovf)
  );

  int checks = 0;
  int fails  = 0;
  int done_cnt = 0;
  logic [N*DW-1:0] log_data [$];
  int              log_row  [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] relu(input logic [DW-1:0] w);
`ifdef SYS_DRAIN_RELU_EN
    return w[DW-1] ? '0 : w;
`else
    return w;
`endif
  endfunction

  // Behavioural model: per-column arrival queues, a row pointer, and flags.
  logic [DW-1:0] mq [N][$];
  bit m_run, m_done, m_ovf;
  int m_row;

  function automatic bit m_valid();
    if (!m_run) return 1'b0;
    for (int j = 0; j < N; j++) if (mq[j].size() <= m_row) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_run = 0; m_done = 0; m_ovf = 0; m_row = 0;
      for (int j = 0; j < N; j++) mq[j].delete();
    end else if (m_done) begin
      m_done = 0;
    end else if (!m_run) begin
      if (start) begin
        m_run = 1; m_row = 0; m_ovf = 0;
        for (int j = 0; j < N; j++) mq[j].delete();
      end
    end else begin : run_upd
      bit acc;
      acc = m_valid() && out_ready;
      for (int j = 0; j < N; j++) begin
        if (sv[j]) begin
          if (mq[j].size() < N) mq[j].push_back(south[j*DW +: DW]);
          else m_ovf = 1;
        end
      end
      if (acc) begin
        if (m_row == N - 1) begin m_run = 0; m_done = 1; end
        else m_row++;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin : cmp
      bit ev;
      ev = m_valid();
      chk("busy", busy, m_run);
      chk("done", done, m_done);
      chk("overflow", ovf, m_ovf);
      chk("out_valid", out_valid, ev);
      if (ev) begin
        chk("out_row", out_row, m_row);
        for (int j = 0; j < N; j++)
          chk($sformatf("out_data_c%0d", j), out_data[j*DW +: DW], relu(mq[j][m_row]));
      end
      if (out_valid && out_ready) begin
        log_data.push_back(out_data);
        log_row.push_back(out_row);
      end
      if (done) done_cnt++;
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic set_col(input int j, input logic [DW-1:0] v);
    south[j*DW +: DW] = v;
  endtask

  task automatic wait_done(input int budget, input string name);
    int d0;
    int n;
    d0 = done_cnt;
    n  = 0;
    while (done_cnt == d0 && n < budget) begin step(); n++; end
    chk(name, done_cnt != d0, 1);
  endtask

  task automatic check_matrix(input string tag, input logic [DW-1:0] e [N][N]);
    logic [N*DW-1:0] row_v;
    chk({tag, "_rows"}, log_data.size(), N);
    for (int r = 0; r < N && r < log_data.size(); r++) begin
      row_v = log_data[r];
      chk($sformatf("%s_idx%0d", tag, r), log_row[r], r);
      for (int j = 0; j < N; j++)
        chk($sformatf("%s_r%0d_c%0d", tag, r, j), row_v[j*DW +: DW], e[r][j]);
    end
  endtask

  task automatic run_aligned();
    start = 1; step(); start = 0;
    out_ready = 1;
    for (int r = 0; r < N; r++) begin
      sv = '1;
      for (int j = 0; j < N; j++) set_col(j, 10 * r + j);
      step();
    end
    sv = '0;
  endtask

  logic [DW-1:0] aligned [N][N] = '{'{0, 1, 2, 3}, '{10, 11, 12, 13},
                                    '{20, 21, 22, 23}, '{30, 31, 32, 33}};
  logic [DW-1:0] relu_exp [N][N];
  logic [DW-1:0] col0_in [N] = '{-32'sd5, 32'sd7, -32'sd1, 32'sd0};
  int dc0;
  int n;
  int k [N];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1; start = 0; sv = '0; south = '0; out_ready = 0;
    step(); step();
    chk("rst_valid", out_valid, 0);
    chk("rst_row", out_row, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_data", out_data, 0);
    rst = 0;
    step();

    // Aligned fill
    log_data.delete(); log_row.delete(); dc0 = done_cnt;
    run_aligned();
    wait_done(30, "aligned_done");
    step(); step();
    chk("aligned_done_once", done_cnt - dc0, 1);
    chk("aligned_ovf", ovf, 0);
    check_matrix("aligned", aligned);

    // Skewed arrival: column j delayed by j cycles
    log_data.delete(); log_row.delete();
    start = 1; step(); start = 0; out_ready = 1;
    for (int t = 0; t < 2 * N - 1; t++) begin
      sv = '0;
      for (int j = 0; j < N; j++) begin
        if (t - j >= 0 && t - j < N) begin sv[j] = 1; set_col(j, 10 * (t - j) + j); end
      end
      step();
      if (t == 2) chk("skew_valid_early", out_valid, 0);
      if (t == 3) chk("skew_valid_first", out_valid, 1);
    end
    sv = '0;
    wait_done(30, "skew_done");
    check_matrix("skew", aligned);

    // Backpressure on row 1
    log_data.delete(); log_row.delete();
    start = 1; step(); start = 0; out_ready = 0;
    for (int r = 0; r < N; r++) begin
      sv = '1;
      for (int j = 0; j < N; j++) set_col(j, 10 * r + j);
      step();
    end
    sv = '0; out_ready = 1; step(); out_ready = 0;
    for (int c = 0; c < 5; c++) begin
      chk("bp_row", out_row, 1);
      chk("bp_valid", out_valid, 1);
      for (int j = 0; j < N; j++) chk("bp_data", out_data[j*DW +: DW], 10 + j);
      step();
    end
    out_ready = 1;
    wait_done(30, "bp_done");
    check_matrix("bp", aligned);

    // Overflow on column 2
    log_data.delete(); log_row.delete();
    run_aligned();
    sv = 4'b0100; set_col(2, 99); step(); sv = '0;
    chk("ovf_set", ovf, 1);
    wait_done(30, "ovf_done");
    check_matrix("ovf", aligned);
    step(); step();
    chk("ovf_sticky", ovf, 1);
    start = 1; step(); start = 0;
    chk("ovf_cleared", ovf, 0);
    chk("ovf_busy", busy, 1);

    // Reset mid-RUN (drain already armed above)
    log_data.delete(); log_row.delete(); out_ready = 1;
    for (int r = 0; r < 2; r++) begin
      sv = '1;
      for (int j = 0; j < N; j++) set_col(j, 10 * r + j);
      step();
    end
    sv = '0;
    n = 0;
    while (log_data.size() < 2 && n < 20) begin step(); n++; end
    chk("rst_mid_two_rows", log_data.size(), 2);
    dc0 = done_cnt;
    rst = 1; #1;
    chk("rstm_valid", out_valid, 0);
    chk("rstm_row", out_row, 0);
    chk("rstm_busy", busy, 0);
    chk("rstm_done", done, 0);
    chk("rstm_data", out_data, 0);
    step(); step(); rst = 0; step(); step();
    chk("rstm_no_done", done_cnt - dc0, 0);
    log_data.delete(); log_row.delete();
    run_aligned();
    wait_done(30, "rstm_redo_done");
    check_matrix("rstm_redo", aligned);

    // Sign handling on column 0
    log_data.delete(); log_row.delete();
    relu_exp = aligned;
`ifdef SYS_DRAIN_RELU_EN
    relu_exp[0][0] = 0; relu_exp[1][0] = 7; relu_exp[2][0] = 0; relu_exp[3][0] = 0;
`else
    relu_exp[0][0] = 32'hFFFF_FFFB; relu_exp[1][0] = 7;
    relu_exp[2][0] = 32'hFFFF_FFFF; relu_exp[3][0] = 0;
`endif
    start = 1; step(); start = 0; out_ready = 1;
    for (int r = 0; r < N; r++) begin
      sv = '1;
      set_col(0, col0_in[r]);
      for (int j = 1; j < N; j++) set_col(j, 10 * r + j);
      step();
    end
    sv = '0;
    wait_done(30, "relu_done");
    check_matrix("relu", relu_exp);

    // Randomized matrices with skew, backpressure and occasional overflow
    for (int m = 0; m < 12; m++) begin
      dc0 = done_cnt;
      start = 1; step(); start = 0;
      for (int j = 0; j < N; j++) k[j] = 0;
      n = 0;
      while (done_cnt == dc0 && n < 300) begin
        out_ready = ($urandom_range(0, 3) != 0);
        for (int j = 0; j < N; j++) begin
          if (k[j] < N) sv[j] = $urandom_range(0, 1);
          else          sv[j] = ($urandom_range(0, 15) == 0);
          set_col(j, $urandom);
          if (sv[j]) k[j]++;
        end
        step();
        n++;
      end
      sv = '0;
      chk("rand_done", done_cnt != dc0, 1);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/systolic_result_drain.md
# systolic_result_drain

Result collector downstream of the systolic array with input queues. It captures the per-column results leaving the array's south edge and buffers each column independently, since column results arrive skewed in time. It then re-emits them as aligned, row-major result rows on a valid/ready stream toward the writeback stage. It also signals completion and flags overflow.

## Interface
Parameters:
- N, 8, array dimension; number of columns and rows per result matrix
- DATA_WIDTH, 32, width of one result element (two's complement)

Ports:
- clk_i  input  1  clock; all state updates on its rising edge
- rst_i  input  1  reset; asynchronous and active-high, clears all state
- start_i  input  1  arms the drain for one N×N result matrix
- south_i  input  N×DATA_WIDTH  per-column result from the array's bottom row
- south_valid_i  input  N  per-column qualifier for south_i
- out_data_o  output  N×DATA_WIDTH  one aligned result row
- out_valid_o  output  1  out_data_o holds a complete row
- out_ready_i  input  1  downstream accepts the row
- out_row_o  output  $clog2(N)  index of the row on out_data_o
- busy_o  output  1  drain is armed (RUN state)
- done_o  output  1  one-cycle pulse after the last row is accepted
- overflow_o  output  1  sticky; a column received more than N values

## Operation
- FSM states are IDLE, RUN and DONE.
- IDLE → RUN on start_i. Entering RUN clears all column counts, the row pointer and overflow_o.
- RUN → DONE on the cycle where row N-1 is accepted (out_valid_o && out_ready_i).
- DONE → IDLE unconditionally after one cycle. done_o=1 only in DONE.
- Capture happens only in RUN. For each column j with south_valid_i[j]=1:
  - If cnt[j] < N: write buf[j][cnt[j]] = south_i[j] and increment cnt[j].
  - Else: drop the value and set overflow_o.
- Columns capture independently; any subset may be valid in the same cycle.
- Emit: out_valid_o = RUN && (cnt[j] > row for every j). out_data_o[j] = buf[j][row], and out_row_o = row.
- Accept: out_valid_o && out_ready_i increments row. The pointer has no wrap-around; row N-1 acceptance ends the matrix.
- Capture and accept in the same cycle are both performed. A capture landing in row ≥ row+1 does not disturb the row currently presented.
- Stall: while out_valid_o=1 and out_ready_i=0, out_data_o and out_row_o are held stable. Capture continues.
- start_i is ignored outside IDLE. south_valid_i is ignored outside RUN.
- Width: cnt is $clog2(N+1) bits. No arithmetic is performed on data; it passes through bit-exact (except under the macro below).

## Timing
- Reset values: out_valid_o=0, out_row_o=0, busy_o=0, done_o=0, overflow_o=0, out_data_o=0 (buffers cleared), state IDLE.
- Capture latency: a value sampled at edge k is visible on out_data_o from the cycle after edge k, provided its row is current and all columns are present.
- out_valid_o is a combinational function of registered state only. It never depends combinationally on out_ready_i or on the south inputs.
- The next row may be presented in the cycle after an accept, giving a throughput of one row per cycle.
- busy_o is high from the cycle after start_i through the last accept.
- done_o fires in the cycle after the last accept.
- Reset asserted mid-RUN returns to IDLE immediately. Buffered data is discarded and no done_o is produced.

## Configuration
- SYS_DRAIN_RELU_EN
  - Defined: each out_data_o element whose sign bit is set is driven as 0; non-negative values pass unchanged. This is combinational on the output with no added latency. Buffers still hold the raw values.
  - Undefined: out_data_o is the raw buffered value.

## Structure
- The shared package holds:
  - result-row typedef (array of N DATA_WIDTH words)
  - drain FSM state enum (IDLE, RUN, DONE)
  - column-count width constant
- One sub-module, result_column_buffer, is instantiated N times. Each instance is an N-deep write-once buffer with its own count, a capture port and an indexed read port.

## Test plan
- Aligned fill (N=4): start, then four cycles with all valid and column j carrying 10*r+j, out_ready_i=1. Rows 0..3 emerge as {0,1,2,3},{10,11,12,13},{20,21,22,23},{30,31,32,33}; done_o pulses once; overflow_o=0.
- Skewed arrival: column j delayed by j cycles. Row 0 valid only the cycle after column 3's first write, and each row matches the aligned case.
- Backpressure: out_ready_i=0 for 5 cycles while row 1 is presented. out_data_o and out_row_o=1 stay stable, and no rows are lost or duplicated.
- Overflow: a fifth value on column 2 sets overflow_o=1, which stays set until the next start_i; emitted data is unchanged.
- Reset mid-RUN: assert rst_i after two rows. All outputs return to reset values, with no done_o. A new start then produces a full, correct matrix.
- ReLU (macro defined): column 0 supplies -5, 7, -1, 0. Emitted column 0 is 0, 7, 0, 0. Without the macro it is -5, 7, -1, 0.
